// File: rtl/arduino_adc_pio_pkg.sv
// rtl/arduino_adc_pio_pkg.sv - shared register map constants for the Arduino ADC PIO blocks
//
// Purpose: address decode constants and bus width shared by the sensor input
//          PIO and the motor output PIO on the same interconnect.
// Ports:   none (package).
`timescale 1ns/1ps

package arduino_adc_pio_pkg;

    localparam int PIO_DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/arduino_adc_sensor_in_if.sv
// rtl/arduino_adc_sensor_in_if.sv - Avalon-MM slave register bus plus interrupt for the sensor PIO
//
// Purpose: bundles the register-access signals and the interrupt line.
// Signals:
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data
//   irq               level interrupt to the CPU
// Modports: master (CPU/interconnect side), slave (PIO side).
`timescale 1ns/1ps

interface arduino_adc_sensor_in_if;
    import arduino_adc_pio_pkg::*;

    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [PIO_DATA_W-1:0] writedata;
    logic [PIO_DATA_W-1:0] readdata;
    logic                  irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/arduino_adc_debounce.sv
// rtl/arduino_adc_debounce.sv - single-bit synchronizer and debounce filter
//
// Purpose: brings one asynchronous sensor line into the clk domain through a
//          SYNC_STAGES flop chain and, when SENSOR_DEBOUNCE_EN is defined,
//          only lets the filtered level follow the synchronized level after it
//          has differed for DEBOUNCE_CYCLES consecutive cycles. With the macro
//          undefined the filtered level is the synchronized level.
// Config macro: SENSOR_DEBOUNCE_EN
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   din    in   asynchronous sensor input
//   filt   out  filtered level
`timescale 1ns/1ps

module arduino_adc_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SENSOR_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    // The counter counts consecutive cycles of disagreement; any cycle of
    // agreement restarts it, so a glitch shorter than DEBOUNCE_CYCLES is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            filt_q <= 1'b0;
        end else if (sync == filt_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt_q <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync;
`endif

endmodule

// File: rtl/arduino_adc_sensor_in.sv
// rtl/arduino_adc_sensor_in.sv - Avalon-MM sensor input PIO with edge capture and interrupt
//
// Purpose: samples WIDTH external sensor/limit-switch lines, synchronizes and
//          debounces them, latches rising edges and raises an interrupt on
//          masked edges.
// Config macro: SENSOR_DEBOUNCE_EN (enables the debounce counters in
//          arduino_adc_debounce; otherwise lines are only synchronized).
// Register map: 0 DATA (RO), 1 reserved (reads 0), 2 IRQMASK (RW),
//          3 EDGECAP (RW1C).
// Ports:
//   clk      in     system clock
//   reset    in     asynchronous, active-high reset
//   in_port  in     WIDTH asynchronous sensor inputs
//   bus      slave  address/chipselect/write_n/writedata in,
//                   readdata (registered, 1-cycle latency)/irq out
`timescale 1ns/1ps

module arduino_adc_sensor_in
    import arduino_adc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_port,
    arduino_adc_sensor_in_if.slave bus
);

    logic [WIDTH-1:0]      filt;
    logic [WIDTH-1:0]      filt_d;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      irq_mask;
    logic [WIDTH-1:0]      edge_cap;
    logic [WIDTH-1:0]      edge_clr;
    logic [PIO_DATA_W-1:0] rd_mux;
    logic [PIO_DATA_W-1:0] readdata_q;
    logic                  irq_q;
    logic                  wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        arduino_adc_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[i]),
            .filt  (filt[i])
        );
    end

    if (WIDTH < PIO_DATA_W) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^bus.writedata[PIO_DATA_W-1:WIDTH];
    end

    assign wr_en    = bus.chipselect && !bus.write_n;
    assign rise     = filt & ~filt_d;
    assign edge_clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0]
                                                            : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_d     <= '0;
            irq_mask   <= '0;
            edge_cap   <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            filt_d <= filt;

            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end

            // OR-ing rise after the clear makes a same-cycle set win.
            edge_cap <= (edge_cap & ~edge_clr) | rise;

            if (bus.chipselect) begin
                readdata_q <= rd_mux;
            end

            irq_q <= |(edge_cap & irq_mask);
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_arduino_adc_sensor_in.sv
// tb/tb_arduino_adc_sensor_in.sv - directed scoreboard bench for arduino_adc_sensor_in
`timescale 1ns/1ps

module tb_arduino_adc_sensor_in;
    import arduino_adc_pio_pkg::*;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 8;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int FD = DEB;
`else
    localparam int FD = 0;
`endif
    // Edges from driving a line high until readdata/edgecap reflects it.
    localparam int LAT = SYNC + FD + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_port = '0;

    arduino_adc_sensor_in_if bus_if();

    arduino_adc_sensor_in #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        exp_t e;
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        step(1);
        bus_if.chipselect = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, bus_if.readdata, e.exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        step(1);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic settle();
        in_port = '0;
        step(LAT + 4);
        wr(ADDR_EDGECAP, 32'hF);
        step(1);
    endtask

    initial begin
        exp_t e;
        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        // Bring up, let all lines go high, then reset mid-cycle.
        step(3);
        reset = 1'b0;
        in_port = 4'hF;
        step(LAT + 4);
        rd("pre_reset_data", ADDR_DATA, 32'hF);
        #4;
        reset = 1'b1;
        #1;
        chk("async_reset_readdata", bus_if.readdata, 32'h0);
        chk("async_reset_irq", {31'h0, bus_if.irq}, 32'h0);
        step(2);
        reset = 1'b0;

        // Line held high through release: rise shows after exactly LAT edges.
        rd("reset_edgecap", ADDR_EDGECAP, 32'h0);
        chk("reset_irq", {31'h0, bus_if.irq}, 32'h0);
        for (int k = 2; k <= LAT; k++) begin
            rd("reset_data_lat", ADDR_DATA, (k == LAT) ? 32'hF : 32'h0);
        end
        rd("reset_irqmask", ADDR_IRQMASK, 32'h0);
        rd("reset_edgecap_set", ADDR_EDGECAP, 32'hF);
        chk("reset_irq_masked", {31'h0, bus_if.irq}, 32'h0);
        wr(ADDR_DATA, 32'h0);
        wr(2'd1, 32'hF);
        rd("data_write_ignored", ADDR_DATA, 32'hF);
        settle();
        rd("edgecap_cleared", ADDR_EDGECAP, 32'h0);

`ifdef SENSOR_DEBOUNCE_EN
        // 7-cycle glitch is one short of DEB and must be filtered out.
        in_port[0] = 1'b1;
        step(DEB - 1);
        in_port[0] = 1'b0;
        step(LAT + 4);
        rd("glitch_data", ADDR_DATA, 32'h0);
        rd("glitch_edgecap", ADDR_EDGECAP, 32'h0);
`else
        // Single-cycle synchronized pulse is captured without debounce.
        in_port[2] = 1'b1;
        step(1);
        in_port[2] = 1'b0;
        step(LAT + 4);
        rd("pulse1_edgecap", ADDR_EDGECAP, 32'h4);
        settle();
`endif

        // 20-cycle pulse: DATA bit0 appears exactly LAT edges after driving.
        in_port[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            rd("pulse_data_lat", ADDR_DATA, (k == LAT) ? 32'h1 : 32'h0);
        end
        rd("pulse_edgecap", ADDR_EDGECAP, 32'h1);
        step(20 - (LAT + 1));
        settle();

        // Unmasked edge on bit 1 raises irq, W1C drops it a cycle later.
        wr(ADDR_IRQMASK, 32'h2);
        in_port[1] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            rd("irq_edgecap", ADDR_EDGECAP, (k >= LAT + 1) ? 32'h2 : 32'h0);
            chk("irq_rise", {31'h0, bus_if.irq}, (k >= LAT + 1) ? 32'h1 : 32'h0);
        end
        wr(ADDR_EDGECAP, 32'h2);
        chk("irq_hold_after_clear", {31'h0, bus_if.irq}, 32'h1);
        step(1);
        chk("irq_drop_after_clear", {31'h0, bus_if.irq}, 32'h0);
        rd("irq_edgecap_clear", ADDR_EDGECAP, 32'h0);
        wr(ADDR_IRQMASK, 32'h0);
        settle();

        // Masked edge on bit 3, then unmask.
        in_port[3] = 1'b1;
        step(LAT + 2);
        rd("masked_edgecap", ADDR_EDGECAP, 32'h8);
        chk("masked_irq", {31'h0, bus_if.irq}, 32'h0);
        wr(ADDR_IRQMASK, 32'h8);
        chk("unmask_irq_wait", {31'h0, bus_if.irq}, 32'h0);
        step(1);
        chk("unmask_irq", {31'h0, bus_if.irq}, 32'h1);
        wr(ADDR_IRQMASK, 32'h0);
        step(1);
        chk("remask_irq", {31'h0, bus_if.irq}, 32'h0);
        settle();

        // W1C lands on the same edge that sets bit 0: set must win.
        in_port[0] = 1'b1;
        step(LAT - 1);
        wr(ADDR_EDGECAP, 32'h1);
        rd("collision_edgecap", ADDR_EDGECAP, 32'h1);
        settle();

        // Read latency, reserved address, hold when deselected.
        wr(ADDR_IRQMASK, 32'h5);
        rd("reserved_addr", 2'd1, 32'h0);
        bus_if.address    = ADDR_IRQMASK;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #3;
        chk("latency_pre_edge", bus_if.readdata, 32'h0);
        e.tag = "latency_post_edge";
        e.exp = 32'h5;
        sb.push_back(e);
        step(1);
        bus_if.chipselect = 1'b0;
        e = sb.pop_front();
        chk(e.tag, bus_if.readdata, e.exp);
        bus_if.address = ADDR_EDGECAP;
        step(2);
        chk("readdata_hold", bus_if.readdata, 32'h5);
        rd("final_data", ADDR_DATA, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
